// File: rtl/bubble_collapse_pipe.sv
// Bubble-collapsing register pipeline, valid/ready on both sides; DEPTH-1 cycles input-to-output when unstalled.
// A stalled output lets upstream words close gaps; in_ready drops only when every stage is full.
module bubble_collapse_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow_err
);
  localparam int LIM = 2 * DEPTH;
  localparam int SW  = $clog2(LIM + 1);

  logic [DEPTH-1:0]            vld_q, vld_d, adv;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]            occ_q, occ_d;
  logic [SW-1:0]               stall_q, stall_d;
  logic                        err_q, err_d;
  logic                        accept, consume, stall;

  // A stage may move when the next one is empty or is itself moving this cycle.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = vld_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = vld_q[i] & (~vld_q[i+1] | adv[i+1]);
    end
  end

  assign in_ready = (~vld_q[0] | adv[0]) & ~flush;
  assign accept   = in_valid & in_ready;
  assign consume  = adv[DEPTH-1] & ~flush;
  assign stall    = in_valid & ~in_ready & ~flush;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (adv[i]) begin
          vld_d[i+1]  = 1'b1;
          data_d[i+1] = data_q[i];
        end else if (adv[i+1]) begin
          vld_d[i+1] = 1'b0;
        end
      end
      if (accept) begin
        vld_d[0]  = 1'b1;
        data_d[0] = in_data;
      end else if (adv[0]) begin
        vld_d[0] = 1'b0;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !consume) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (consume && !accept) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  // Counts consecutive refused offers; saturates once the limit is reached.
  always_comb begin
    stall_d = '0;
    err_d   = err_q;
    if (stall) begin
      stall_d = (stall_q == SW'(LIM)) ? stall_q : stall_q + SW'(1);
      if (stall_q >= SW'(LIM)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      data_q  <= '0;
      occ_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign out_valid    = vld_q[DEPTH-1];
  assign out_data     = data_q[DEPTH-1];
  assign occupancy    = occ_q;
  assign overflow_err = err_q;

endmodule

// File: tb/tb_bubble_collapse_pipe.sv
// Directed bench for bubble_collapse_pipe with a scoreboard queue tracking accepted words in order.
module tb_bubble_collapse_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] occupancy;
  logic             overflow_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] sb[$];

  bubble_collapse_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n consecutive words base, base+1, ... then go idle.
  task automatic send_n(input logic [WIDTH-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = base + WIDTH'(k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: sampled mid-cycle, before the edge that performs the transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("occ_vs_sb", 32'(occupancy), 32'(sb.size()));
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          chk("sb_nonempty", 32'(sb.size() > 0), 32'h1);
          if (sb.size() > 0) chk("sb_order", 32'(out_data), 32'(sb.pop_front()));
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] stream [4];
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_overflow", 32'(overflow_err), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    tick();

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = stream[k];
      tick();
      if (k == 1) chk("stream_not_yet", 32'(out_valid), 32'h0);
      if (k == 2) begin
        chk("stream_first_vld", 32'(out_valid), 32'h1);
        chk("stream_first_dat", 32'(out_data), 32'h11);
        chk("stream_occ_peak", 32'(occupancy), 32'h3);
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stream_drained", 32'(occupancy), 32'h0);
    out_ready = 1'b0;

    // Backpressure fill and release.
    send_n(8'hA1, 3);
    in_valid = 1'b1; in_data = 8'hA4;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    chk("bp_occ_full", 32'(occupancy), 32'h3);
    chk("bp_head", 32'(out_data), 32'hA1);
    tick(); tick();
    chk("bp_head_stable", 32'(out_data), 32'hA1);
    chk("bp_vld_stable", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_2", 32'(out_data), 32'hA2);
    tick();
    chk("bp_rel_3", 32'(out_data), 32'hA3);
    tick();
    chk("bp_rel_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Bubble compaction: word, idle, word, with the consumer stalled.
    in_valid = 1'b1; in_data = 8'h05; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h06; tick();
    in_valid = 1'b0; tick();
    chk("bub_occ", 32'(occupancy), 32'h2);
    chk("bub_head", 32'(out_data), 32'h05);
    chk("bub_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("bub_adjacent_vld", 32'(out_valid), 32'h1);
    chk("bub_adjacent_dat", 32'(out_data), 32'h06);
    tick();
    chk("bub_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Full pipeline: accept and consume on the same edge.
    send_n(8'h01, 3);
    in_valid = 1'b1; in_data = 8'h04; out_ready = 1'b1;
    #1;
    chk("sim_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("sim_occ", 32'(occupancy), 32'h3);
    chk("sim_head", 32'(out_data), 32'h02);
    repeat (3) tick();
    chk("sim_drained", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Flush a full pipeline while a word is offered.
    send_n(8'hB1, 3);
    in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0; in_data = 8'h77;
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    chk("fl_occ", 32'(occupancy), 32'h0);
    tick();
    in_valid = 1'b0;
    chk("fl_occ_one", 32'(occupancy), 32'h1);
    tick();
    chk("fl_77_not_yet", 32'(out_valid), 32'h0);
    tick();
    chk("fl_77_vld", 32'(out_valid), 32'h1);
    chk("fl_77_dat", 32'(out_data), 32'h77);
    tick();
    out_ready = 1'b0;

    // Asynchronous reset between edges.
    send_n(8'hD1, 3);
    chk("ar_pre_vld", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'h0);
    chk("ar_out_data", 32'(out_data), 32'h0);
    chk("ar_occ", 32'(occupancy), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_post_vld", 32'(out_valid), 32'h0);

    // Sustained refused offers raise the sticky error.
    send_n(8'hC0, 3);
    in_valid = 1'b1; in_data = 8'hCF;
    repeat (6) tick();
    chk("ovf_not_yet", 32'(overflow_err), 32'h0);
    tick();
    chk("ovf_set", 32'(overflow_err), 32'h1);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovf_survives_flush", 32'(overflow_err), 32'h1);
    chk("ovf_flush_occ", 32'(occupancy), 32'h0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("ovf_cleared_by_rst", 32'(overflow_err), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
